// File: rtl/capture_arbiter_pkg.sv
// Shared types and defaults for the capture-path two-input packet arbiter.
package capture_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS0 = 2'd1,
    ST_PASS1 = 2'd2,
    ST_DROP1 = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_CNT_WIDTH = 32;

endpackage

// File: rtl/capture_arbiter_if.sv
// AXI4-Stream bundle used for the arbiter's inputs and its merged output.
interface capture_arbiter_if #(
  parameter int unsigned DataWidth = 256,
  parameter int unsigned UserWidth = 128
);
  logic [DataWidth-1:0]   tdata;
  logic [DataWidth/8-1:0] tstrb;
  logic [UserWidth-1:0]   tuser;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/capture_arbiter_axis_out_reg.sv
// Single-stage AXI4-Stream output register without skid buffer; the caller loads a beat
// only while o_ready is high.
module capture_arbiter_axis_out_reg #(
  parameter int unsigned DataWidth = 256,
  parameter int unsigned UserWidth = 128
) (
  input  logic                   axi_aclk,
  input  logic                   axi_resetn,
  input  logic                   i_load,
  input  logic [DataWidth-1:0]   i_tdata,
  input  logic [DataWidth/8-1:0] i_tstrb,
  input  logic [UserWidth-1:0]   i_tuser,
  input  logic                   i_tlast,
  output logic                   o_ready,
  capture_arbiter_if.master      m_axis
);

  assign o_ready = !m_axis.tvalid || m_axis.tready;

  always_ff @(posedge axi_aclk) begin
    if (axi_resetn) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tstrb  <= '0;
      m_axis.tuser  <= '0;
      m_axis.tlast  <= 1'b0;
    end else if (i_load) begin
      m_axis.tvalid <= 1'b1;
      m_axis.tdata  <= i_tdata;
      m_axis.tstrb  <= i_tstrb;
      m_axis.tuser  <= i_tuser;
      m_axis.tlast  <= i_tlast;
    end else if (m_axis.tready) begin
      m_axis.tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/capture_arbiter.sv
// Packet-granular round-robin merge of the forwarding (port 0) and capture (port 1) copies,
// with capture-enable draining of port 1 and per-port packet/drop statistics.
module capture_arbiter
  import capture_arbiter_pkg::*;
#(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_CNT_WIDTH          = DEFAULT_CNT_WIDTH
) (
  input  logic                   axi_aclk,
  input  logic                   axi_resetn,
  capture_arbiter_if.slave       s_axis_0,
  capture_arbiter_if.slave       s_axis_1,
  capture_arbiter_if.master      m_axis,
  input  logic                   cfg_capture_en,
  output logic [C_CNT_WIDTH-1:0] stat_pkt_0,
  output logic [C_CNT_WIDTH-1:0] stat_pkt_1,
  output logic [C_CNT_WIDTH-1:0] stat_drop_1
);

  state_e                           r_state, w_state_next, w_port1_state;
  logic                             r_rr_pref;
  logic [C_CNT_WIDTH-1:0]           r_pkt0, r_pkt1, r_drop1;
  logic                             w_out_ready, w_acc0, w_acc1, w_pkt_end, w_load;
  logic [C_S_AXIS_DATA_WIDTH-1:0]   w_tdata;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] w_tstrb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  w_tuser;
  logic                             w_tlast;

  // cfg_capture_en only matters at grant time, so a mid-packet change cannot split a packet.
  assign w_port1_state = cfg_capture_en ? ST_PASS1 : ST_DROP1;

  assign w_acc0    = s_axis_0.tvalid && s_axis_0.tready;
  assign w_acc1    = s_axis_1.tvalid && s_axis_1.tready;
  assign w_pkt_end = (w_acc0 && s_axis_0.tlast) || (w_acc1 && s_axis_1.tlast);
  assign w_load    = w_acc0 || (w_acc1 && (r_state == ST_PASS1));

  assign w_tdata = (r_state == ST_PASS1) ? s_axis_1.tdata : s_axis_0.tdata;
  assign w_tstrb = (r_state == ST_PASS1) ? s_axis_1.tstrb : s_axis_0.tstrb;
  assign w_tuser = (r_state == ST_PASS1) ? s_axis_1.tuser : s_axis_0.tuser;
  assign w_tlast = (r_state == ST_PASS1) ? s_axis_1.tlast : s_axis_0.tlast;

  always_comb begin
    w_state_next    = r_state;
    s_axis_0.tready = 1'b0;
    s_axis_1.tready = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (s_axis_0.tvalid && s_axis_1.tvalid) begin
          w_state_next = r_rr_pref ? w_port1_state : ST_PASS0;
        end else if (s_axis_0.tvalid) begin
          w_state_next = ST_PASS0;
        end else if (s_axis_1.tvalid) begin
          w_state_next = w_port1_state;
        end
      end
      ST_PASS0: s_axis_0.tready = w_out_ready;
      ST_PASS1: s_axis_1.tready = w_out_ready;
      ST_DROP1: s_axis_1.tready = 1'b1;
      default: ;
    endcase
    if (w_pkt_end) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_resetn) begin
      r_state   <= ST_IDLE;
      r_rr_pref <= 1'b0;
      r_pkt0    <= '0;
      r_pkt1    <= '0;
      r_drop1   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pkt_end) begin
        r_rr_pref <= (r_state == ST_PASS0);
        unique case (r_state)
          ST_PASS0: r_pkt0  <= r_pkt0 + 1'b1;
          ST_PASS1: r_pkt1  <= r_pkt1 + 1'b1;
          ST_DROP1: r_drop1 <= r_drop1 + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign stat_pkt_0  = r_pkt0;
  assign stat_pkt_1  = r_pkt1;
  assign stat_drop_1 = r_drop1;

  capture_arbiter_axis_out_reg #(
    .DataWidth(C_M_AXIS_DATA_WIDTH),
    .UserWidth(C_M_AXIS_TUSER_WIDTH)
  ) u_out_reg (
    .axi_aclk  (axi_aclk),
    .axi_resetn(axi_resetn),
    .i_load    (w_load),
    .i_tdata   (w_tdata),
    .i_tstrb   (w_tstrb),
    .i_tuser   (w_tuser),
    .i_tlast   (w_tlast),
    .o_ready   (w_out_ready),
    .m_axis    (m_axis)
  );

endmodule

// File: tb/tb_capture_arbiter.sv
// Randomized packet-level bench for capture_arbiter against a round-robin scoreboard model.
module tb_capture_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned UW = 16;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic              first;
    logic              last;
    logic [DW/8-1:0]   strb;
    logic [UW-1:0]     user;
    logic [DW-1:0]     data;
  } beat_t;
  typedef logic [DW+UW+DW/8:0] obeat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg = 1'b1;
  logic [CW-1:0] stat_pkt_0, stat_pkt_1, stat_drop_1;

  capture_arbiter_if #(.DataWidth(DW), .UserWidth(UW)) s_if [2] ();
  capture_arbiter_if #(.DataWidth(DW), .UserWidth(UW)) m ();

  capture_arbiter #(
    .C_M_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_M_AXIS_TUSER_WIDTH(UW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .C_CNT_WIDTH         (CW)
  ) dut (
    .axi_aclk      (clk),
    .axi_resetn    (rst),
    .s_axis_0      (s_if[0]),
    .s_axis_1      (s_if[1]),
    .m_axis        (m),
    .cfg_capture_en(cfg),
    .stat_pkt_0    (stat_pkt_0),
    .stat_pkt_1    (stat_pkt_1),
    .stat_drop_1   (stat_drop_1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_pct = 100;
  int bubble_pct = 0;
  int s1_rdy_cnt = 0;
  beat_t  src_q [2][$];
  obeat_t out_q[$];
  int     out_cyc[$];
  int m_pkt0 = 0, m_pkt1 = 0, m_drop1 = 0;
  bit m_rr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Source drivers: first beat of a packet is never withheld, later beats may bubble.
  for (genvar p = 0; p < 2; p++) begin : g_drv
    initial begin
      bit hs;
      s_if[p].tvalid = 1'b0;
      s_if[p].tdata  = '0;
      s_if[p].tstrb  = '0;
      s_if[p].tuser  = '0;
      s_if[p].tlast  = 1'b0;
      forever begin
        @(negedge clk);
        hs = s_if[p].tvalid && s_if[p].tready;
        @(posedge clk);
        #1;
        if (hs && src_q[p].size() > 0) void'(src_q[p].pop_front());
        if (src_q[p].size() == 0) begin
          s_if[p].tvalid = 1'b0;
        end else begin
          if (!s_if[p].tvalid || hs)
            s_if[p].tvalid = src_q[p][0].first || ($urandom_range(99) >= bubble_pct);
          s_if[p].tdata = src_q[p][0].data;
          s_if[p].tstrb = src_q[p][0].strb;
          s_if[p].tuser = src_q[p][0].user;
          s_if[p].tlast = src_q[p][0].last;
        end
      end
    end
  end

  initial begin
    m.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m.tready = ($urandom_range(99) < ready_pct);
    end
  end

  // Output monitor: records accepted beats and checks hold-while-stalled.
  initial begin
    bit     stall;
    obeat_t prev, cur;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      cur = {m.tlast, m.tstrb, m.tuser, m.tdata};
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", m.tvalid, 1);
          check("hold_data", cur, prev);
        end
        if (s_if[1].tready) begin
          s1_rdy_cnt++;
          check("tready_excl", s_if[0].tready, 0);
        end
        if (m.tvalid && m.tready) begin
          out_q.push_back(cur);
          out_cyc.push_back(cyc);
        end
        stall = m.tvalid && !m.tready;
        prev  = cur;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_model();
    m_pkt0 = 0;
    m_pkt1 = 0;
    m_drop1 = 0;
    m_rr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_q[0].delete();
    src_q[1].delete();
    step();
    step();
    rst = 1'b0;
    clear_model();
    step();
  endtask

  task automatic run_phase(input string tag, input int n0, input int n1, input bit cfg_v,
                           input int rdy, input int bub, input int len_lo, input int len_hi,
                           input int flip_at, input bit chk_gap);
    int     lens [2][$];
    beat_t  bq [2][$];
    obeat_t exp_q[$];
    int     sel, len, nmin;
    bit     done;
    cfg = cfg_v;
    ready_pct = rdy;
    bubble_pct = bub;
    for (int p = 0; p < 2; p++) begin
      int n = (p == 0) ? n0 : n1;
      for (int i = 0; i < n; i++) begin
        len = $urandom_range(len_hi, len_lo);
        lens[p].push_back(len);
        for (int b = 0; b < len; b++) begin
          beat_t bt;
          bt.first = (b == 0);
          bt.last  = (b == len - 1);
          bt.data  = DW'($urandom);
          bt.user  = UW'($urandom);
          bt.strb  = (DW/8)'($urandom);
          bq[p].push_back(bt);
        end
      end
    end
    out_q.delete();
    out_cyc.delete();
    s1_rdy_cnt = 0;
    src_q[0] = bq[0];
    src_q[1] = bq[1];
    // Packet-level model: both queues are presented at once, so arbitration is pure rr.
    while (lens[0].size() > 0 || lens[1].size() > 0) begin
      if (lens[0].size() > 0 && lens[1].size() > 0) sel = m_rr;
      else sel = (lens[0].size() > 0) ? 0 : 1;
      len = lens[sel].pop_front();
      for (int b = 0; b < len; b++) begin
        beat_t bt;
        bt = bq[sel].pop_front();
        if (sel == 0 || cfg_v) exp_q.push_back({bt.last, bt.strb, bt.user, bt.data});
      end
      if (sel == 0) m_pkt0++;
      else if (cfg_v) m_pkt1++;
      else m_drop1++;
      m_rr = (sel == 0);
    end
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      step();
      if (flip_at > 0 && out_q.size() >= flip_at) cfg = 1'b0;
      done = (src_q[0].size() == 0) && (src_q[1].size() == 0) && !m.tvalid;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_nbeats"}, out_q.size(), exp_q.size());
    nmin = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) check({tag, "_beat"}, out_q[i], exp_q[i]);
    if (chk_gap) begin
      for (int i = 1; i < nmin; i++)
        check({tag, "_gap"}, out_cyc[i] - out_cyc[i-1], exp_q[i-1][DW+UW+DW/8] ? 2 : 1);
    end
    check({tag, "_pkt0"}, stat_pkt_0, m_pkt0 % (1 << CW));
    check({tag, "_pkt1"}, stat_pkt_1, m_pkt1 % (1 << CW));
    check({tag, "_drop1"}, stat_drop_1, m_drop1 % (1 << CW));
  endtask

  initial begin
    bit got;
    // Reset state after the first edge with reset high.
    step();
    check("rst_tvalid", m.tvalid, 0);
    check("rst_tdata", m.tdata, 0);
    check("rst_tuser", m.tuser, 0);
    check("rst_tstrb", m.tstrb, 0);
    check("rst_tlast", m.tlast, 0);
    check("rst_tready0", s_if[0].tready, 0);
    check("rst_tready1", s_if[1].tready, 0);
    check("rst_pkt0", stat_pkt_0, 0);
    check("rst_pkt1", stat_pkt_1, 0);
    check("rst_drop1", stat_drop_1, 0);
    rst = 1'b0;
    clear_model();
    step();

    run_phase("alt", 2, 2, 1'b1, 100, 0, 3, 3, 0, 1'b1);
    check("alt_pkt0_2", stat_pkt_0, 2);
    check("alt_pkt1_2", stat_pkt_1, 2);

    run_phase("drop", 0, 1, 1'b0, 0, 0, 4, 4, 0, 1'b0);
    check("drop_tready_cycles", s1_rdy_cnt, 4);
    check("drop_cnt", stat_drop_1, 1);

    run_phase("bp", 1, 0, 1'b1, 50, 0, 5, 5, 0, 1'b0);
    check("bp_s1_ready", s1_rdy_cnt, 0);

    run_phase("cfgflip", 0, 1, 1'b1, 100, 0, 4, 4, 2, 1'b0);
    run_phase("cfgoff", 0, 1, 1'b0, 100, 0, 2, 4, 0, 1'b0);

    // Reset during beat 3 of a 6-beat packet.
    cfg = 1'b1;
    ready_pct = 100;
    bubble_pct = 0;
    out_q.delete();
    for (int b = 0; b < 6; b++) begin
      beat_t bt;
      bt = '{first: (b == 0), last: (b == 5), strb: 4'hF, user: UW'(b), data: DW'(32'hA0 + b)};
      src_q[0].push_back(bt);
    end
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      step();
      got = (out_q.size() >= 2);
    end
    check("midrst_reach", got, 1);
    rst = 1'b1;
    src_q[0].delete();
    src_q[1].delete();
    step();
    check("midrst_tvalid", m.tvalid, 0);
    check("midrst_tready0", s_if[0].tready, 0);
    check("midrst_pkt0", stat_pkt_0, 0);
    check("midrst_pkt1", stat_pkt_1, 0);
    check("midrst_drop1", stat_drop_1, 0);
    step();
    rst = 1'b0;
    clear_model();
    step();
    run_phase("postrst", 1, 1, 1'b1, 100, 0, 1, 4, 0, 1'b0);

    do_reset();
    run_phase("wrap", 17, 0, 1'b1, 70, 0, 1, 1, 0, 1'b0);
    check("wrap_pkt0", stat_pkt_0, 1);

    for (int r = 0; r < 8; r++) begin
      run_phase("rand", $urandom_range(4, 0), $urandom_range(4, 0), 1'($urandom_range(1, 0)),
                $urandom_range(100, 30), $urandom_range(40, 0), 1, 5, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/capture_arbiter.md
# capture_arbiter

Packet-granular two-input AXI4-Stream arbiter that merges the forwarding copy (port 0) and capture copy (port 1) produced by the packet duplicator into a single output stream toward the output queues. It replaces the generic five-queue input arbiter in the capture pipeline. It adds three things:
- round-robin fairness between the two copies;
- a capture-enable control that silently drains port 1 when capture is off;
- per-port packet and drop statistics.

## Interface
Parameters:
- C_M_AXIS_DATA_WIDTH, 256, output tdata width.
- C_S_AXIS_DATA_WIDTH, 256, input tdata width; must equal C_M_AXIS_DATA_WIDTH.
- C_M_AXIS_TUSER_WIDTH, 128, output tuser width.
- C_S_AXIS_TUSER_WIDTH, 128, input tuser width; must equal C_M_AXIS_TUSER_WIDTH.
- C_CNT_WIDTH, 32, statistics counter width.

Ports:
- axi_aclk  in  1  single clock; every register is clocked on its rising edge.
- axi_resetn  in  1  synchronous reset, active-high. The name matches the arbiter port convention; the polarity is high, not low.
- s_axis_{tdata,tstrb,tuser,tvalid,tready,tlast}_0  in/out  DATA/DATA÷8/TUSER/1/1(out)/1  forwarding copy.
- s_axis_{tdata,tstrb,tuser,tvalid,tready,tlast}_1  in/out  same widths  capture copy.
- m_axis_{tdata,tstrb,tuser,tvalid,tready,tlast}  out/in  same widths  merged stream; tready is the only input.
- cfg_capture_en  in  1  when 1, port 1 packets are forwarded; when 0, they are drained and dropped.
- stat_pkt_0  out  C_CNT_WIDTH  packets forwarded from port 0.
- stat_pkt_1  out  C_CNT_WIDTH  packets forwarded from port 1.
- stat_drop_1  out  C_CNT_WIDTH  packets dropped from port 1.

## Operation
State machine, one-hot or encoded:
- **IDLE**: no grant. Pick a requester (see selection rules below).
- **PASS0**: port 0 granted; its beats are forwarded.
- **PASS1**: port 1 granted; its beats are forwarded.
- **DROP1**: port 1 granted; its beats are accepted and discarded.

Selection in IDLE, per cycle:
- Requesters are s_axis_tvalid_0 and s_axis_tvalid_1.
- If both are valid, grant the port indicated by the round-robin pointer `rr_pref`. Its reset value is 0.
- If exactly one is valid, grant that port.
- A port 1 grant goes to PASS1 if cfg_capture_en is 1, otherwise to DROP1.

Grant lifetime:
- A grant holds until a beat with tlast is accepted on the granted input. The FSM then returns to IDLE.

Round-robin pointer update, on packet end:
- End in PASS0: `rr_pref` ← 1.
- End in PASS1 or DROP1: `rr_pref` ← 0.

cfg_capture_en:
- Sampled only in IDLE.
- A change mid-packet does not affect the packet in flight.

DROP1 handling:
- s_axis_tready_1 = 1 every cycle, independent of m_axis_tready.
- Nothing is written to the output register.

Counters:
- Each counter increments by 1 on the accepted tlast beat of the relevant packet.
- Counters wrap from 2^C_CNT_WIDTH−1 to 0.
- At most one counter increments per cycle.

Payload:
- tdata, tstrb and tuser pass through unmodified.
- tuser is captured on every beat.

## Timing
Output stage:
- A single output register, with no skid buffer.
- Input tready for the granted port in PASS0/PASS1 is `(!m_axis_tvalid || m_axis_tready)`.
- Non-granted tready is 0.

Latency and throughput:
- An input beat accepted in cycle N appears on m_axis in cycle N+1.
- Sustained throughput is 1 beat/cycle within a packet.
- IDLE costs exactly one cycle between packets, so the inter-packet gap is ≥1 cycle.

Output handshake rules:
- m_axis_tvalid stays high, with stable data, until m_axis_tready is sampled high.
- It clears the cycle after acceptance unless a new beat is loaded in the same cycle.

Reset (axi_resetn = 1 at a clock edge):
- Next cycle values: state = IDLE, `rr_pref` = 0, m_axis_tvalid = 0, m_axis_tdata/tstrb/tuser/tlast = 0, both s_axis_tready = 0, all stat counters = 0.
- A packet in flight at reset is truncated and its partial output is discarded. There is no tlast recovery.

Boundary conditions:
- A single-beat packet (tvalid and tlast in the same beat) returns to IDLE the next cycle.
- If m_axis_tready is low for many cycles in PASSx, input stalls and the grant holds. DROP1 is unaffected by output backpressure.

## Structure
- A shared package holds:
  - state encoding constants ST_IDLE, ST_PASS0, ST_PASS1, ST_DROP1;
  - the default counter width.
- A natural sub-module is axis_out_reg. It is the single-stage output register carrying the tdata/tstrb/tuser/tlast/tvalid handshake and is reusable elsewhere in the pipeline.
- The FSM, round-robin pointer and counters live in the top module.

## Test plan
- **Both ports valid, alternating.** Port 0 and port 1 each present 3-beat packets back to back with cfg_capture_en = 1 and m_axis_tready = 1.
  - Output order: P0, P1, P0, P1, with a 1-cycle gap between packets.
  - stat_pkt_0 = 2, stat_pkt_1 = 2.
- **Capture disabled.** cfg_capture_en = 0; port 1 sends a 4-beat packet while m_axis_tready = 0.
  - s_axis_tready_1 is high for 4 cycles and no m_axis beats are produced.
  - stat_drop_1 = 1, stat_pkt_1 = 0.
- **Backpressure mid-packet.** m_axis_tready toggles 1,0,0,1 during a 5-beat port 0 packet.
  - All 5 beats appear in order, each held stable while not accepted.
  - s_axis_tready_1 stays 0 throughout.
- **cfg change mid-packet.** cfg_capture_en drops 1→0 on beat 2 of a 4-beat port 1 packet.
  - The whole packet is forwarded.
  - The next port 1 packet is dropped.
- **Reset mid-packet.** Assert axi_resetn during beat 3 of a 6-beat packet.
  - Next cycle: m_axis_tvalid = 0, counters = 0, state = IDLE.
  - A fresh packet after reset passes correctly.
- **Counter wrap.** Run with C_CNT_WIDTH = 4 and 17 port 0 packets.
  - stat_pkt_0 ends at 1.
